mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the 16-bit RISC pipeline, between execute and write-back. It performs data-memory loads and stores, sequences multi-register LM/SM transfers one register per cycle and stalls upstream while it does so. Its output register is the MEM/WB pipeline register, which drives the write-back selection muxes with MemData, ALUOut, PCInc, Imm970, PCImmInc, RFOut2 and the regSelect/r7Select codes.

## Interface
Parameters:
- DW, 16, datapath and address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  EX/MEM slot holds an instruction.
- in_op  in  3  000 none/ALU, 001 LW, 010 SW, 011 LM, 100 SM; other codes are treated as 000.
- in_addr  in  DW  effective address / ALUOut.
- in_store_data  in  DW  SW data (RFOut2).
- in_mask  in  8  LM/SM register mask; bit i selects Ri.
- in_dest  in  3  destination register.
- in_reg_wr  in  1  instruction writes a register.
- in_pc_inc, in_pc_imm_inc, in_imm970  in  DW  passthrough values.
- in_reg_select  in  2  passthrough; in_r7_select  in  3  passthrough.
- stall_out  out  1  hold EX/MEM and earlier stages this cycle.
- mem_addr  out  DW; mem_wdata  out  DW; mem_we  out  1; mem_re  out  1.
- mem_rdata  in  DW  combinational read data for mem_addr.
- rf_rd_addr  out  3; rf_rd_data  in  DW  extra register-file read port for SM.
- wb_valid, wb_reg_wr  out  1; wb_dest  out  3.
- wb_mem_data, wb_alu_out, wb_pc_inc, wb_pc_imm_inc, wb_imm970, wb_rf_out2  out  DW.
- wb_reg_select  out  2; wb_r7_select  out  3.

## Operation
- FSM states are IDLE and MULTI. The latched copy holds addr, mask, store data and passthroughs.
- IDLE, no valid or op none:
  - The memory strobes stay low.
  - On each clock edge the WB register loads the passthrough values; wb_valid = in_valid and wb_mem_data = 0.
- LW: mem_re = 1 and mem_addr = in_addr. On the clock edge, wb_mem_data <= mem_rdata and the other fields pass through.
- SW: mem_we = 1, mem_addr = in_addr and mem_wdata = in_store_data. wb_reg_wr <= 0.
- LM/SM:
  - Registers are processed from lowest set bit to highest.
  - Access k (k = 0, 1, ...) uses address base + k, modulo 2^16.
  - In the first cycle the inputs are used directly. If more bits remain, the latched copy is loaded and the FSM goes IDLE -> MULTI.
  - MULTI clears the serviced bit each cycle. When the last bit has been serviced, MULTI -> IDLE.
- LM access: mem_re = 1. WB receives wb_valid = 1, wb_reg_wr = 1, wb_dest = i, wb_mem_data = mem_rdata and wb_reg_select = 00. If i = 7, wb_r7_select = 001.
- SM access: rf_rd_addr = i, mem_we = 1 and mem_wdata = rf_rd_data. WB receives wb_valid = 1 and wb_reg_wr = 0.
- LM/SM with mask = 0: no memory access; a single WB slot with wb_valid = 1 and wb_reg_wr = 0.
- stall_out is combinational. It is 1 when at least one set mask bit remains after the current access, whether in IDLE on the first access of a multi-bit LM/SM or in MULTI. While in MULTI the block ignores its in_* inputs.
- mem_we and mem_re are never high together.

## Timing
- Reset: state = IDLE, latched mask = 0, and every wb_* output = 0. stall_out, mem_we and mem_re are 0.
- Reset asserted mid-LM/SM aborts the transfer immediately; the remaining registers are not written.
- Latency from EX/MEM to WB is one cycle. LM/SM with n set bits takes n cycles and raises stall_out for n-1 cycles.
- Memory writes commit on the clock edge; reads are combinational within the cycle.

## Configuration
- MEM_STAGE_LMSM_EN defined: LM/SM sequencing is compiled in as described above.
- Not defined:
  - op codes 011 and 100 behave as op none.
  - stall_out is tied to 0; the FSM, the latched copy and the rf_rd_addr logic are removed.
  - rf_rd_addr = 0.

## Test plan
- LW, in_addr = 0x0040, memory[0x0040] = 0xBEEF, in_dest = 3 -> one cycle later wb_valid = 1, wb_reg_wr = 1, wb_dest = 3, wb_mem_data = 0xBEEF, and the passthroughs match the inputs.
- SW, in_addr = 0x0012, in_store_data = 0x1234 -> mem_we pulses for 1 cycle, memory[0x0012] = 0x1234, wb_reg_wr = 0, stall_out = 0.
- LM, base 0x0010, mask 8'b1000_0101, memory[0x10..0x12] = 0xA, 0xB, 0xC -> stall_out high for 2 cycles, then WB writes R0 = 0xA, R2 = 0xB, R7 = 0xC with wb_r7_select = 001 on the R7 write.
- SM, base 0xFFFF, mask 8'b0000_0110, R1 = 0x1111, R2 = 0x2222 -> memory[0xFFFF] = 0x1111 and memory[0x0000] = 0x2222 (address wraps); 1 stall cycle.
- LM with mask 0 -> no mem_re, a single wb_valid = 1 slot with wb_reg_wr = 0, and no stall.
- LM with mask 0xFF, reset asserted on the 3rd access -> all wb_* outputs and stall_out are 0 immediately. The next LW after reset completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Memory-access stage of the 16-bit RISC pipeline. Performs
//               LW/SW data-memory accesses, sequences LM/SM multi-register
//               transfers one register per cycle (stalling upstream), and
//               owns the MEM/WB pipeline register.
//               Optional feature macro: MEM_STAGE_LMSM_EN
//                 defined   -> LM/SM sequencing FSM compiled in
//                 undefined -> LM/SM decode as op none, stall_out = 0
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [2:0]    in_op,
    input  logic [DW-1:0] in_addr,
    input  logic [DW-1:0] in_store_data,
    input  logic [7:0]    in_mask,
    input  logic [2:0]    in_dest,
    input  logic          in_reg_wr,
    input  logic [DW-1:0] in_pc_inc,
    input  logic [DW-1:0] in_pc_imm_inc,
    input  logic [DW-1:0] in_imm970,
    input  logic [1:0]    in_reg_select,
    input  logic [2:0]    in_r7_select,
    output logic          stall_out,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    rf_rd_addr,
    input  logic [DW-1:0] rf_rd_data,
    output logic          wb_valid,
    output logic          wb_reg_wr,
    output logic [2:0]    wb_dest,
    output logic [DW-1:0] wb_mem_data,
    output logic [DW-1:0] wb_alu_out,
    output logic [DW-1:0] wb_pc_inc,
    output logic [DW-1:0] wb_pc_imm_inc,
    output logic [DW-1:0] wb_imm970,
    output logic [DW-1:0] wb_rf_out2,
    output logic [1:0]    wb_reg_select,
    output logic [2:0]    wb_r7_select
);

    localparam logic [2:0] c_OP_NONE = 3'b000;
    localparam logic [2:0] c_OP_LW   = 3'b001;
    localparam logic [2:0] c_OP_SW   = 3'b010;
    localparam logic [2:0] c_OP_LM   = 3'b011;
    localparam logic [2:0] c_OP_SM   = 3'b100;

    // MULTI owns the stage: upstream inputs are ignored while it is set
    logic w_busy;
    logic w_in_act;
    logic w_is_lw;
    logic w_is_sw;

    // WB register next values
    logic          w_wb_valid;
    logic          w_wb_reg_wr;
    logic [2:0]    w_wb_dest;
    logic [DW-1:0] w_wb_mem_data;
    logic [DW-1:0] w_wb_alu_out;
    logic [DW-1:0] w_wb_pc_inc;
    logic [DW-1:0] w_wb_pc_imm_inc;
    logic [DW-1:0] w_wb_imm970;
    logic [DW-1:0] w_wb_rf_out2;
    logic [1:0]    w_wb_reg_select;
    logic [2:0]    w_wb_r7_select;

    // Reset also squashes the combinational strobes so nothing leaks out
    assign w_in_act = in_valid & ~reset & ~w_busy;
    assign w_is_lw  = w_in_act & (in_op == c_OP_LW);
    assign w_is_sw  = w_in_act & (in_op == c_OP_SW);

`ifdef MEM_STAGE_LMSM_EN
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_MULTI = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;

    // Latched copy of the multi-register instruction
    logic [7:0]    r_mask;
    logic [DW-1:0] r_next_addr;
    logic          r_is_lm;
    logic [DW-1:0] r_alu_out;
    logic [DW-1:0] r_store_data;
    logic [2:0]    r_dest;
    logic          r_reg_wr;
    logic [DW-1:0] r_pc_inc;
    logic [DW-1:0] r_pc_imm_inc;
    logic [DW-1:0] r_imm970;
    logic [1:0]    r_reg_select;
    logic [2:0]    r_r7_select;

    logic          w_is_lm;
    logic          w_is_sm;
    logic          w_seq_active;
    logic          w_seq_lm;
    logic [7:0]    w_seq_mask;
    logic [7:0]    w_seq_rest;
    logic          w_seq_more;
    logic          w_seq_access;
    logic [DW-1:0] w_seq_addr;
    logic [2:0]    w_bit_idx;

    // Selected passthroughs: inputs on the first access, latched copy after
    logic [DW-1:0] w_pt_alu_out;
    logic [DW-1:0] w_pt_store_data;
    logic [2:0]    w_pt_dest;
    logic [DW-1:0] w_pt_pc_inc;
    logic [DW-1:0] w_pt_pc_imm_inc;
    logic [DW-1:0] w_pt_imm970;
    logic [1:0]    w_pt_reg_select;
    logic [2:0]    w_pt_r7_select;

    assign w_busy       = (r_state == c_ST_MULTI);
    assign w_is_lm      = w_in_act & (in_op == c_OP_LM);
    assign w_is_sm      = w_in_act & (in_op == c_OP_SM);
    assign w_seq_active = w_busy | w_is_lm | w_is_sm;
    assign w_seq_lm     = w_busy ? r_is_lm     : w_is_lm;
    assign w_seq_mask   = w_busy ? r_mask      : in_mask;
    assign w_seq_addr   = w_busy ? r_next_addr : in_addr;
    // Clearing the lowest set bit leaves the registers still to be serviced
    assign w_seq_rest   = w_seq_mask & (w_seq_mask - 8'd1);
    assign w_seq_more   = w_seq_active & (w_seq_rest != 8'd0);
    assign w_seq_access = w_seq_active & (w_seq_mask != 8'd0);

    assign w_pt_alu_out    = w_busy ? r_alu_out    : in_addr;
    assign w_pt_store_data = w_busy ? r_store_data : in_store_data;
    assign w_pt_dest       = w_busy ? r_dest       : in_dest;
    assign w_pt_pc_inc     = w_busy ? r_pc_inc     : in_pc_inc;
    assign w_pt_pc_imm_inc = w_busy ? r_pc_imm_inc : in_pc_imm_inc;
    assign w_pt_imm970     = w_busy ? r_imm970     : in_imm970;
    assign w_pt_reg_select = w_busy ? r_reg_select : in_reg_select;
    assign w_pt_r7_select  = w_busy ? r_r7_select  : in_r7_select;

    // Lowest set mask bit selects the register serviced this cycle
    always_comb begin
        w_bit_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_seq_mask[i]) begin
                w_bit_idx = 3'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: stay in MULTI until no mask bits remain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_seq_more)  w_state_nxt = c_ST_MULTI;
            c_ST_MULTI: if (!w_seq_more) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Latched copy: captured on a multi-bit first access, advanced in MULTI
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask       <= 8'd0;
            r_next_addr  <= '0;
            r_is_lm      <= 1'b0;
            r_alu_out    <= '0;
            r_store_data <= '0;
            r_dest       <= 3'd0;
            r_reg_wr     <= 1'b0;
            r_pc_inc     <= '0;
            r_pc_imm_inc <= '0;
            r_imm970     <= '0;
            r_reg_select <= 2'd0;
            r_r7_select  <= 3'd0;
        end else if (!w_busy && w_seq_more) begin
            r_mask       <= w_seq_rest;
            r_next_addr  <= in_addr + DW'(1);
            r_is_lm      <= w_is_lm;
            r_alu_out    <= in_addr;
            r_store_data <= in_store_data;
            r_dest       <= in_dest;
            r_reg_wr     <= in_reg_wr;
            r_pc_inc     <= in_pc_inc;
            r_pc_imm_inc <= in_pc_imm_inc;
            r_imm970     <= in_imm970;
            r_reg_select <= in_reg_select;
            r_r7_select  <= in_r7_select;
        end else if (w_busy) begin
            r_mask      <= w_seq_rest;
            r_next_addr <= r_next_addr + DW'(1);
        end
    end

    // r_reg_wr is kept for completeness of the latched copy only
    logic w_unused_lmsm;
    assign w_unused_lmsm = r_reg_wr;
`else
    assign w_busy = 1'b0;

    // Mask and extra read port have no function without LM/SM support
    logic w_unused_lmsm;
    assign w_unused_lmsm = ^{in_mask, rf_rd_data};
`endif

    // FSM outputs: memory strobes, stall and SM register read address
    always_comb begin
        mem_addr   = in_addr;
        mem_wdata  = in_store_data;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        rf_rd_addr = 3'd0;
        stall_out  = 1'b0;
        if (w_is_lw) begin
            mem_re = 1'b1;
        end else if (w_is_sw) begin
            mem_we = 1'b1;
        end
`ifdef MEM_STAGE_LMSM_EN
        if (w_seq_access) begin
            mem_addr = w_seq_addr;
            if (w_seq_lm) begin
                mem_re = 1'b1;
            end else begin
                rf_rd_addr = w_bit_idx;
                mem_we     = 1'b1;
                mem_wdata  = rf_rd_data;
            end
        end
        stall_out = w_seq_more;
`endif
    end

    // WB next values: passthroughs by default, overridden per operation
    always_comb begin
        w_wb_valid      = in_valid;
        w_wb_reg_wr     = in_reg_wr;
        w_wb_dest       = in_dest;
        w_wb_mem_data   = '0;
        w_wb_alu_out    = in_addr;
        w_wb_pc_inc     = in_pc_inc;
        w_wb_pc_imm_inc = in_pc_imm_inc;
        w_wb_imm970     = in_imm970;
        w_wb_rf_out2    = in_store_data;
        w_wb_reg_select = in_reg_select;
        w_wb_r7_select  = in_r7_select;
        if (w_is_lw) begin
            w_wb_mem_data = mem_rdata;
        end
        if (w_is_sw) begin
            w_wb_reg_wr = 1'b0;
        end
`ifdef MEM_STAGE_LMSM_EN
        if (w_seq_active) begin
            w_wb_valid      = 1'b1;
            w_wb_reg_wr     = 1'b0;
            w_wb_dest       = w_pt_dest;
            w_wb_mem_data   = '0;
            w_wb_alu_out    = w_pt_alu_out;
            w_wb_pc_inc     = w_pt_pc_inc;
            w_wb_pc_imm_inc = w_pt_pc_imm_inc;
            w_wb_imm970     = w_pt_imm970;
            w_wb_rf_out2    = w_pt_store_data;
            w_wb_reg_select = w_pt_reg_select;
            w_wb_r7_select  = w_pt_r7_select;
            if (w_seq_access && w_seq_lm) begin
                w_wb_reg_wr     = 1'b1;
                w_wb_dest       = w_bit_idx;
                w_wb_mem_data   = mem_rdata;
                w_wb_reg_select = 2'b00;
                if (w_bit_idx == 3'd7) begin
                    w_wb_r7_select = 3'b001;
                end
            end
        end
`endif
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_wr     <= 1'b0;
            wb_dest       <= 3'd0;
            wb_mem_data   <= '0;
            wb_alu_out    <= '0;
            wb_pc_inc     <= '0;
            wb_pc_imm_inc <= '0;
            wb_imm970     <= '0;
            wb_rf_out2    <= '0;
            wb_reg_select <= 2'd0;
            wb_r7_select  <= 3'd0;
        end else begin
            wb_valid      <= w_wb_valid;
            wb_reg_wr     <= w_wb_reg_wr;
            wb_dest       <= w_wb_dest;
            wb_mem_data   <= w_wb_mem_data;
            wb_alu_out    <= w_wb_alu_out;
            wb_pc_inc     <= w_wb_pc_inc;
            wb_pc_imm_inc <= w_wb_pc_imm_inc;
            wb_imm970     <= w_wb_imm970;
            wb_rf_out2    <= w_wb_rf_out2;
            wb_reg_select <= w_wb_reg_select;
            wb_r7_select  <= w_wb_r7_select;
        end
    end

endmodule
`default_nettype wire
